exu_lsu_ctrl: RTL

EXU_LSU_CTRL -- requirements
Module: exu_lsu_ctrl

---
 rtl/exu_lsu_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/exu_lsu_ctrl.sv
// Load/store unit bus controller: takes one AGU access at a time, issues it
// on the memory request channel, waits for the response (or a timeout) and
// hands the result back to the AGU for one cycle.
module exu_lsu_ctrl #(
  parameter int unsigned TMO_CYC = 255   // WAIT cycles without rvalid before timeout (1..1023)
) (
  input  logic        clk,
  input  logic        rst_n,
  // AGU side
  input  logic        hs_ag4ls_val,
  output logic        hs_ls4ag_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic [31:0] o_ls_rdat,
  output logic        o_ls_err,
  // memory request channel
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_adr,
  output logic [31:0] o_bus_wdat,
  // grant / response channel
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdat,
  input  logic        i_bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [9:0] TMO_LAST = 10'(TMO_CYC - 1);

  state_t      r_state, w_nxt;
  logic [31:0] r_adr, r_wdat, r_rdat;
  logic [3:0]  r_be;
  logic        r_we, r_err, r_flush;
  logic [9:0]  r_cnt;

  logic w_wr, w_acc, w_accept, w_rsp, w_tmo;

  assign w_wr     = |i_ls_wen;
  assign w_acc    = hs_ag4ls_val & (i_ls_ren | w_wr);
  assign w_accept = (r_state == S_IDLE) & w_acc;
  // a response wins over a timeout in the same cycle
  assign w_rsp    = (r_state == S_WAIT) & i_bus_rvalid;
  assign w_tmo    = (r_state == S_WAIT) & ~i_bus_rvalid & (r_cnt == TMO_LAST);

  // bus fields always reflect the latched access; they only matter while o_bus_req is high
  assign o_bus_we   = r_we;
  assign o_bus_be   = r_be;
  assign o_bus_adr  = r_adr;
  assign o_bus_wdat = r_wdat;

  // next-state and AGU/bus handshake outputs
  always_comb begin
    w_nxt        = r_state;
    hs_ls4ag_rdy = 1'b0;
    o_ls_err     = 1'b0;
    o_ls_rdat    = 32'h0;
    o_bus_req    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc)             w_nxt = S_REQ;
        else if (hs_ag4ls_val) hs_ls4ag_rdy = 1'b1;  // non-access: complete immediately
      end
      S_REQ: begin
        o_bus_req = 1'b1;
        if (i_bus_gnt)          w_nxt = S_WAIT;
        else if (!hs_ag4ls_val) w_nxt = S_IDLE;      // flushed before grant: withdraw
      end
      S_WAIT: begin
        if (w_rsp || w_tmo) w_nxt = S_DONE;
      end
      S_DONE: begin
        hs_ls4ag_rdy = ~r_flush;
        o_ls_err     = r_err & ~r_flush;
        o_ls_rdat    = r_rdat;
        w_nxt        = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // latch the access on acceptance; reads always use all byte lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr  <= 32'h0;
      r_wdat <= 32'h0;
      r_be   <= 4'h0;
      r_we   <= 1'b0;
    end else if (w_accept) begin
      r_adr  <= i_ls_adr;
      r_wdat <= i_ls_wdat;
      r_be   <= w_wr ? i_ls_wen : 4'hF;
      r_we   <= w_wr;
    end
  end

  // WAIT-cycle counter, restarted on every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     r_cnt <= 10'h0;
    else if (r_state == S_REQ)                      r_cnt <= 10'h0;
    else if (r_state == S_WAIT && !w_rsp && !w_tmo) r_cnt <= r_cnt + 10'h1;
  end

  // capture response word / error; timeout reports err with a zero word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdat <= 32'h0;
      r_err  <= 1'b0;
    end else if (w_rsp) begin
      r_rdat <= r_we ? 32'h0 : i_bus_rdat;
      r_err  <= i_bus_err;
    end else if (w_tmo) begin
      r_rdat <= 32'h0;
      r_err  <= 1'b1;
    end
  end

  // flush flag: AGU dropped val once the bus transaction was committed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                r_flush <= 1'b0;
    else if (w_accept)                                         r_flush <= 1'b0;
    else if (r_state == S_REQ && i_bus_gnt && !hs_ag4ls_val)   r_flush <= 1'b1;
    else if (r_state == S_WAIT && !hs_ag4ls_val)               r_flush <= 1'b1;
  end

endmodule
